// File: rtl/conv_stream_k.sv
// Streaming K x K signed convolver over an N x N raster-order map with stride S,
// runtime serial weight loading and saturating accumulation.
module conv_stream_k #(
  parameter int N  = 4,
  parameter int K  = 3,
  parameter int S  = 1,
  parameter int DW = 16,
  parameter int AW = 32
) (
  input  logic                 clk,
  input  logic                 global_rst_n,
  input  logic                 ce,
  input  logic signed [DW-1:0] activation,
  input  logic                 wt_load,
  input  logic                 w_valid,
  input  logic signed [DW-1:0] w_data,
  output logic signed [AW-1:0] conv_op,
  output logic                 valid_conv,
  output logic                 end_conv,
  output logic                 loading
);

  localparam int KK   = K * K;
  localparam int LBW  = (K - 1) * N + K;
  localparam int FW   = 2 * DW + $clog2(KK);
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int IW   = $clog2(KK);
  localparam int LAST = (K - 1) + ((N - K) / S) * S;

  localparam logic signed [FW-1:0] MAXV = {{(FW - AW + 1){1'b0}}, {(AW - 1){1'b1}}};
  localparam logic signed [FW-1:0] MINV = {{(FW - AW + 1){1'b1}}, {(AW - 1){1'b0}}};

  typedef enum logic {ST_RUN, ST_LOAD} state_t;

  state_t                state_q;
  logic [CW-1:0]         row_q, col_q;
  logic [IW-1:0]         idx_q;
  logic signed [DW-1:0]  weight_q [KK];
  logic signed [DW-1:0]  lb_q [LBW];
  logic signed [DW-1:0]  lb_d [LBW];
  logic signed [AW-1:0]  conv_q;
  logic                  valid_q, end_q, loading_q;

  logic signed [2*DW-1:0] prod;
  logic signed [FW-1:0]   sum_full;
  logic signed [AW-1:0]   sat_d;
  logic                   accept, row_ok, col_ok, hit, last_hit;

  assign accept   = (state_q == ST_RUN) && ce && !wt_load;
  assign row_ok   = (int'(row_q) >= K - 1) && (((int'(row_q) - (K - 1)) % S) == 0);
  assign col_ok   = (int'(col_q) >= K - 1) && (((int'(col_q) - (K - 1)) % S) == 0);
  assign hit      = row_ok && col_ok;
  assign last_hit = (int'(row_q) == LAST) && (int'(col_q) == LAST);

  // Window is taken from the post-shift buffer so the completing pixel is tap (K-1,K-1).
  always_comb begin
    lb_d[0] = activation;
    for (int k = 1; k < LBW; k++) lb_d[k] = lb_q[k-1];
  end

  // NOTE: blocking assignments here are intentional; prod and sum_full are
  // combinational temporaries that accumulate within one evaluation.
  always_comb begin
    prod     = '0;
    sum_full = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        prod     = lb_d[(K - 1 - i) * N + (K - 1 - j)] * weight_q[i * K + j];
        sum_full = sum_full + FW'(prod);
      end
    end
  end

  always_comb begin
    sat_d = sum_full[AW-1:0];
    if (sum_full > MAXV)      sat_d = MAXV[AW-1:0];
    else if (sum_full < MINV) sat_d = MINV[AW-1:0];
  end

  // NOTE: the line buffer has no reset; its content is never observed until
  // K-1 fresh rows have been shifted in after reset or a weight load.
  always_ff @(posedge clk) begin
    if (accept) lb_q <= lb_d;
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q   <= ST_RUN;
      row_q     <= '0;
      col_q     <= '0;
      idx_q     <= '0;
      conv_q    <= '0;
      valid_q   <= 1'b0;
      end_q     <= 1'b0;
      loading_q <= 1'b0;
      for (int i = 0; i < KK; i++) weight_q[i] <= DW'(i);
    end else begin
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      if (wt_load) begin
        state_q   <= ST_LOAD;
        loading_q <= 1'b1;
        idx_q     <= '0;
        row_q     <= '0;
        col_q     <= '0;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (ce) begin
              if (col_q == CW'(N - 1)) begin
                col_q <= '0;
                row_q <= (row_q == CW'(N - 1)) ? '0 : row_q + CW'(1);
              end else begin
                col_q <= col_q + CW'(1);
              end
              if (hit) begin
                conv_q  <= sat_d;
                valid_q <= 1'b1;
                end_q   <= last_hit;
              end
            end
          end
          ST_LOAD: begin
            if (w_valid) begin
              weight_q[idx_q] <= w_data;
              if (idx_q == IW'(KK - 1)) begin
                state_q   <= ST_RUN;
                loading_q <= 1'b0;
                idx_q     <= '0;
              end else begin
                idx_q <= idx_q + IW'(1);
              end
            end
          end
          default: state_q <= ST_RUN;
        endcase
      end
    end
  end

  assign conv_op    = conv_q;
  assign valid_conv = valid_q;
  assign end_conv   = end_q;
  assign loading    = loading_q;

endmodule

// File: tb/tb_conv_stream_k.sv
// Scoreboard bench for conv_stream_k: drivers queue hand-computed results with the
// cycle they must appear in; monitors pop and compare on every valid_conv.
module tb_conv_stream_k;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce, wt_load, w_valid;
  logic [15:0] activation, w_data;
  logic [31:0] conv_op;
  logic        valid_conv, end_conv, loading;

  logic        ce2;
  logic [15:0] act2;
  logic        wt_load2, w_valid2;
  logic [15:0] w_data2;
  logic [31:0] conv_op2;
  logic        valid_conv2, end_conv2, loading2;

  typedef struct {
    logic [31:0] val;
    bit          last;
    int          cyc;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  logic [31:0] exp_vals [4];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_stream_k dut (
    .clk(clk), .global_rst_n(rst_n), .ce(ce), .activation(activation),
    .wt_load(wt_load), .w_valid(w_valid), .w_data(w_data),
    .conv_op(conv_op), .valid_conv(valid_conv), .end_conv(end_conv), .loading(loading)
  );

  conv_stream_k #(.N(5), .K(3), .S(2), .DW(16), .AW(32)) dut2 (
    .clk(clk), .global_rst_n(rst_n), .ce(ce2), .activation(act2),
    .wt_load(wt_load2), .w_valid(w_valid2), .w_data(w_data2),
    .conv_op(conv_op2), .valid_conv(valid_conv2), .end_conv(end_conv2), .loading(loading2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n === 1'b1) begin
      if (valid_conv) begin
        if (q1.size() == 0) check("dut1_unexpected_valid", 32'(valid_conv), 32'd0);
        else begin
          e = q1.pop_front();
          check("dut1_conv_op", conv_op, e.val);
          check("dut1_end_conv", 32'(end_conv), 32'(e.last));
          check("dut1_valid_cycle", cyc, e.cyc);
        end
      end else if (end_conv) check("dut1_stray_end", 32'(end_conv), 32'd0);
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst_n === 1'b1) begin
      if (valid_conv2) begin
        if (q2.size() == 0) check("dut2_unexpected_valid", 32'(valid_conv2), 32'd0);
        else begin
          e = q2.pop_front();
          check("dut2_conv_op", conv_op2, e.val);
          check("dut2_end_conv", 32'(end_conv2), 32'(e.last));
          check("dut2_valid_cycle", cyc, e.cyc);
        end
      end else if (end_conv2) check("dut2_stray_end", 32'(end_conv2), 32'd0);
    end
  end

  task automatic set_exp(input logic [31:0] a, b, c, d);
    exp_vals[0] = a; exp_vals[1] = b; exp_vals[2] = c; exp_vals[3] = d;
  endtask

  // Called at a negedge; each pixel is sampled at the following posedge.
  task automatic run_frame(input bit use_const, input logic [15:0] cval, input bit stall);
    exp_t e;
    int   k = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        ce         = 1'b1;
        activation = use_const ? cval : 16'(r * 4 + c);
        if (r >= 2 && c >= 2) begin
          e.val  = exp_vals[k];
          e.last = (k == 3);
          e.cyc  = cyc + 1;
          q1.push_back(e);
          k++;
        end
        @(negedge clk);
        if (stall) begin
          ce = 1'b0;
          @(negedge clk);
        end
      end
    end
    ce = 1'b0;
  endtask

  task automatic load_weights(input logic [15:0] val, input bit ce_during, input bit restart);
    wt_load = 1'b1; w_valid = 1'b1; w_data = 16'd99;
    ce = ce_during; activation = 16'd10;
    @(negedge clk);
    wt_load = 1'b0;
    check("loading_rise", 32'(loading), 32'd1);
    if (restart) begin
      for (int i = 0; i < 3; i++) begin
        w_valid = 1'b1; w_data = 16'd5;
        @(negedge clk);
      end
      wt_load = 1'b1; w_valid = 1'b1; w_data = 16'd99;
      @(negedge clk);
      wt_load = 1'b0;
    end
    for (int i = 0; i < 9; i++) begin
      w_valid = 1'b1; w_data = val; activation = 16'(i * 7 + 3);
      @(negedge clk);
      if (i == 4) begin
        w_valid = 1'b0;
        @(negedge clk);
        check("loading_held", 32'(loading), 32'd1);
      end
    end
    w_valid = 1'b0; ce = 1'b0;
    check("loading_fall", 32'(loading), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 20000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; ce = 1'b0; wt_load = 1'b0; w_valid = 1'b0; activation = '0; w_data = '0;
    ce2 = 1'b0; act2 = '0; wt_load2 = 1'b0; w_valid2 = 1'b0; w_data2 = '0;
    repeat (3) @(negedge clk);
    check("rst_conv_op", conv_op, 32'd0);
    check("rst_valid", 32'(valid_conv), 32'd0);
    check("rst_end", 32'(end_conv), 32'd0);
    check("rst_loading", 32'(loading), 32'd0);
    check("rst_dut2_conv_op", conv_op2, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Default weights 0..8, activation 0..15
    set_exp(32'd258, 32'd294, 32'd402, 32'd438);
    run_frame(1'b0, 16'd0, 1'b0);
    repeat (2) @(negedge clk);

    // Two frames back-to-back with no gap
    run_frame(1'b0, 16'd0, 1'b0);
    run_frame(1'b0, 16'd0, 1'b0);
    repeat (2) @(negedge clk);

    // ce toggling every cycle
    run_frame(1'b0, 16'd0, 1'b1);
    repeat (3) @(negedge clk);

    // wt_load mid-frame coincident with the pixel that would complete a window
    for (int p = 0; p < 10; p++) begin
      ce = 1'b1; activation = 16'(p);
      @(negedge clk);
    end
    load_weights(16'd1, 1'b1, 1'b1);
    set_exp(32'd45, 32'd54, 32'd81, 32'd90);
    run_frame(1'b0, 16'd0, 1'b0);
    repeat (2) @(negedge clk);

    // Saturation both ways
    load_weights(16'h7FFF, 1'b0, 1'b0);
    set_exp(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_frame(1'b1, 16'h7FFF, 1'b0);
    set_exp(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    run_frame(1'b1, 16'h8000, 1'b0);
    repeat (2) @(negedge clk);

    // Reset mid-frame restores default weights and counters
    for (int p = 0; p < 6; p++) begin
      ce = 1'b1; activation = 16'(p);
      @(negedge clk);
    end
    rst_n = 1'b0; ce = 1'b0;
    #1;
    check("midrst_conv_op", conv_op, 32'd0);
    check("midrst_valid", 32'(valid_conv), 32'd0);
    check("midrst_loading", 32'(loading), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_exp(32'd258, 32'd294, 32'd402, 32'd438);
    run_frame(1'b0, 16'd0, 1'b0);
    repeat (2) @(negedge clk);

    // N=5, S=2 instance
    begin
      logic [31:0] v2 [4];
      int          k = 0;
      v2[0] = 32'd312; v2[1] = 32'd384; v2[2] = 32'd672; v2[3] = 32'd744;
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          ce2 = 1'b1; act2 = 16'(r * 5 + c);
          if ((r == 2 || r == 4) && (c == 2 || c == 4)) begin
            e.val  = v2[k];
            e.last = (k == 3);
            e.cyc  = cyc + 1;
            q2.push_back(e);
            k++;
          end
          @(negedge clk);
        end
      end
      ce2 = 1'b0;
    end

    repeat (4) @(negedge clk);
    check("dut1_queue_drained", 32'(q1.size()), 32'd0);
    check("dut2_queue_drained", 32'(q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
